rom_line_arbiter: RTL and testbench

Sequencer and two-way arbiter that shares the single-port, one-cycle-latency read-only line memory of the cache subsystem between two miss requesters (instruction-side port 0, data-side port 1). It accepts a line request from one requester at a time and issues BURST_LEN consecutive word reads to the memory. It returns each word tagged with owner and word index, and arbitrates round-robin when both requesters are pending.

---
 rtl/rom_line_arbiter.sv | 121 ++++++++++++
 tb/tb_rom_line_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_line_arbiter.sv
// Round-robin two-port line fetcher in front of a single-port, one-cycle-latency ROM.
// Define ROM_ARB_CRITICAL_WORD_FIRST_EN to start each burst at the requested word.
module rom_line_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req0,
  input  logic [ADDR_W-1:0]            addr0,
  output logic                         gnt0,
  input  logic                         req1,
  input  logic [ADDR_W-1:0]            addr1,
  output logic                         gnt1,
  output logic                         rsp_valid,
  output logic                         rsp_id,
  output logic [$clog2(BURST_LEN)-1:0] rsp_word,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_last,
  output logic                         busy,
  output logic                         rom_enable,
  output logic [ADDR_W-1:0]            rom_address,
  input  logic [DATA_W-1:0]            rom_data
);
  localparam int WORD_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state;
  logic [WORD_W-1:0]          cnt;
  logic [WORD_W-1:0]          start;
  logic [ADDR_W-WORD_W-1:0]   line;
  logic                       last_owner;
  logic                       pick0;
  logic                       pick1;
  logic                       take;
  logic [ADDR_W-1:0]          sel_addr;
  logic [WORD_W-1:0]          sel_start;
  logic [WORD_W-1:0]          next_word;

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (state == IDLE) begin
      if (req0 && req1) begin
        pick0 = last_owner;
        pick1 = ~last_owner;
      end else begin
        pick0 = req0;
        pick1 = req1;
      end
    end
  end

  // Grants are decoded in the accepting IDLE cycle itself, masked while reset is held.
  assign take     = pick0 | pick1;
  assign gnt0     = reset & pick0;
  assign gnt1     = reset & pick1;
  assign sel_addr = pick1 ? addr1 : addr0;

`ifdef ROM_ARB_CRITICAL_WORD_FIRST_EN
  assign sel_start = sel_addr[WORD_W-1:0];
`else
  logic unused_word_bits;
  assign unused_word_bits = ^sel_addr[WORD_W-1:0];
  assign sel_start        = '0;
`endif

  // Word index arithmetic stays WORD_W wide so it wraps inside the line.
  assign next_word = start + cnt + WORD_W'(1);
  assign busy      = (state != IDLE);
  assign rsp_data  = rom_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      start       <= '0;
      line        <= '0;
      last_owner  <= 1'b1;
      rom_enable  <= 1'b0;
      rom_address <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_word    <= '0;
      rsp_last    <= 1'b0;
    end else begin
      rsp_valid <= rom_enable;
      rsp_id    <= rom_enable & last_owner;
      rsp_word  <= rom_enable ? rom_address[WORD_W-1:0] : '0;
      rsp_last  <= rom_enable && (cnt == WORD_W'(BURST_LEN - 1));
      case (state)
        IDLE: begin
          if (take) begin
            last_owner  <= pick1;
            line        <= sel_addr[ADDR_W-1:WORD_W];
            start       <= sel_start;
            cnt         <= '0;
            rom_enable  <= 1'b1;
            rom_address <= {sel_addr[ADDR_W-1:WORD_W], sel_start};
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt == WORD_W'(BURST_LEN - 1)) begin
            cnt         <= '0;
            rom_enable  <= 1'b0;
            rom_address <= '0;
            state       <= DRAIN;
          end else begin
            cnt         <= cnt + WORD_W'(1);
            rom_address <= {line, next_word};
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_line_arbiter.sv
// Directed bench for rom_line_arbiter: cycle table for single bursts plus contention,
// mid-burst reset and back-to-back sequences. ROM word i holds 64'h1000 + i.
module tb_rom_line_arbiter;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 4;
`ifdef ROM_ARB_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic              gnt0, gnt1, rsp_valid, rsp_id, rsp_last, busy, rom_enable;
  logic [1:0]        rsp_word;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data = '0;

  int tests = 0;
  int fails = 0;

  rom_line_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_word(rsp_word),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .rom_enable(rom_enable), .rom_address(rom_address), .rom_data(rom_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_enable) rom_data <= 64'h1000 + 64'(rom_address);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         r0;
    bit         r1;
    logic [5:0] a0;
    logic [5:0] a1;
    bit         g0;
    bit         g1;
    bit         v;
    bit         id;
    logic [1:0] w;
    logic [63:0] d;
    bit         last;
    bit         bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] wexp(input logic [5:0] a, input int k);
    int s;
    s = CWF ? int'(a[1:0]) : 0;
    return 2'((s + k) % BURST_LEN);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " gnt0"}, 64'(gnt0), 64'd0);
    chk({tag, " gnt1"}, 64'(gnt1), 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, " rsp_word"}, 64'(rsp_word), 64'd0);
    chk({tag, " rsp_last"}, 64'(rsp_last), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " rom_enable"}, 64'(rom_enable), 64'd0);
    chk({tag, " rom_address"}, 64'(rom_address), 64'd0);
  endtask

  // One line request from an idle arbiter: grant cycle, issue, four words, back to idle.
  task automatic add_burst(input bit port, input logic [5:0] a);
    vec_t v;
    v = '{default: 0};
    v.r0 = !port;
    v.r1 = port;
    if (port) v.a1 = a; else v.a0 = a;
    v.g0 = !port;
    v.g1 = port;
    vecs.push_back(v);
    v = '{default: 0};
    v.bsy = 1'b1;
    vecs.push_back(v);
    for (int k = 0; k < BURST_LEN; k++) begin
      v = '{default: 0};
      v.bsy  = 1'b1;
      v.v    = 1'b1;
      v.id   = port;
      v.w    = wexp(a, k);
      v.d    = 64'h1000 + 64'(a & 6'h3C) + 64'(v.w);
      v.last = (k == BURST_LEN - 1);
      vecs.push_back(v);
    end
    v = '{default: 0};
    vecs.push_back(v);
  endtask

  initial begin
    int   gcyc[$];
    bit   gown[$];
    bit   cur_own;
    logic [1:0] w;

    add_burst(1'b0, 6'd6);
    add_burst(1'b1, 6'd63);
    add_burst(1'b0, 6'd13);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      @(negedge clock);
      chk($sformatf("vec%0d gnt0", i), 64'(gnt0), 64'(vecs[i].g0));
      chk($sformatf("vec%0d gnt1", i), 64'(gnt1), 64'(vecs[i].g1));
      chk($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].v));
      if (vecs[i].v) begin
        chk($sformatf("vec%0d rsp_id", i), 64'(rsp_id), 64'(vecs[i].id));
        chk($sformatf("vec%0d rsp_word", i), 64'(rsp_word), 64'(vecs[i].w));
        chk($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].d);
      end
      chk($sformatf("vec%0d rsp_last", i), 64'(rsp_last), 64'(vecs[i].last));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].bsy));
      @(posedge clock); #1;
    end

    // Contention from reset release: port 0 first, then strict alternation every 6 cycles.
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 6'd0; addr1 = 6'd8;
    @(negedge clock);
    check_zero("alt_rst");
    @(posedge clock); #1;
    reset = 1'b1;
    cur_own = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clock);
      if (gnt0 || gnt1) begin
        gcyc.push_back(n);
        gown.push_back(gnt1);
        cur_own = gnt1;
        chk($sformatf("alt both_gnt c%0d", n), 64'(gnt0 & gnt1), 64'd0);
      end
      if (rsp_valid) chk($sformatf("alt rsp_id c%0d", n), 64'(rsp_id), 64'(cur_own));
      @(posedge clock); #1;
      if (n == 23) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    chk("alt grant_count", 64'(gcyc.size()), 64'd4);
    for (int k = 0; k < gcyc.size() && k < 4; k++) begin
      chk($sformatf("alt grant%0d cycle", k), 64'(gcyc[k]), 64'(6 * k));
      chk($sformatf("alt grant%0d owner", k), 64'(gown[k]), 64'(k % 2));
    end

    // Reset at the second returned word; pending port 1 is granted on the first idle cycle.
    req0 = 1'b1; addr0 = 6'd0;
    @(negedge clock);
    chk("rstmid gnt0", 64'(gnt0), 64'd1);
    @(posedge clock); #1;
    req0 = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    chk("rstmid valid_before", 64'(rsp_valid), 64'd1);
    reset = 1'b0; req1 = 1'b1; addr1 = 6'd16;
    #1;
    check_zero("rstmid");
    @(posedge clock); #1;
    check_zero("rstmid_hold");
    reset = 1'b1;
    @(negedge clock);
    chk("rstmid gnt1", 64'(gnt1), 64'd1);
    chk("rstmid gnt0", 64'(gnt0), 64'd0);
    @(posedge clock); #1;
    req1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("rstmid valid k%0d", k), 64'(rsp_valid), 64'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        w = wexp(6'd16, k - 2);
        chk($sformatf("rstmid id k%0d", k), 64'(rsp_id), 64'd1);
        chk($sformatf("rstmid data k%0d", k), rsp_data, 64'h1010 + 64'(w));
      end
      chk($sformatf("rstmid last k%0d", k), 64'(rsp_last), 64'(k == 5));
      @(posedge clock); #1;
    end

    // Port 0 held high: accepted again on the first idle cycle after its burst.
    req0 = 1'b1; addr0 = 6'd8;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clock);
      chk($sformatf("b2b gnt0 c%0d", n), 64'(gnt0), 64'(n == 0 || n == 6));
      chk($sformatf("b2b gnt1 c%0d", n), 64'(gnt1), 64'd0);
      @(posedge clock); #1;
      if (n == 6) req0 = 1'b0;
    end
    repeat (6) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("b2b busy_end", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
